// File: rtl/median_stream_if.sv
// median_stream_if: sample-in / median-out valid-ready channels for median_stream.
// The slave modport is the filter's view; the master modport is the source/sink view.
interface median_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/median_stream.sv
// median_stream: streaming 3-tap median filter.
// Keeps the last three accepted samples (w0 newest .. w2 oldest) and, once the
// window is full, sorts a snapshot of it with three sequential compare-exchange
// steps (S1, S2, S3) before presenting the median on the output channel.
// Optional build macro MEDIAN_EDGE_REPLICATE_EN: the first sample after reset or
// flush fills the whole window, so every accepted sample yields a median.
module median_stream #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  median_stream_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] w0_q, w1_q, w2_q;
  logic [WIDTH-1:0] w0_d, w1_d, w2_d;
  logic [WIDTH-1:0] s0_q, s1_q, s2_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             accept;
  logic             load_sort;
  logic [WIDTH-1:0] cx_a, cx_b, cx_lo, cx_hi;

  // Swap only when the left operand is strictly larger; equal values stay put.
  function automatic logic [2*WIDTH-1:0] cmp_exch(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    if (a > b) return {b, a};
    else       return {a, b};
  endfunction

  assign bus.in_ready  = (state_q == IDLE) && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign load_sort = accept && (cnt_d == 2'd3);

  // Next window contents and fill count for this edge.
  always_comb begin
    w0_d  = w0_q;
    w1_d  = w1_q;
    w2_d  = w2_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (accept) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
      if (cnt_q == 2'd0) begin
        w0_d  = bus.in_data;
        w1_d  = bus.in_data;
        w2_d  = bus.in_data;
        cnt_d = 2'd3;
      end else begin
`else
      begin
`endif
        w2_d  = w1_q;
        w1_d  = w0_q;
        w0_d  = bus.in_data;
        cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
      end
    end
  end

  // Select the register pair that the current sort step works on.
  always_comb begin
    cx_a = s0_q;
    cx_b = s1_q;
    if (state_q == S2) begin
      cx_a = s1_q;
      cx_b = s2_q;
    end
    {cx_lo, cx_hi} = cmp_exch(cx_a, cx_b);
  end

  // Sliding window and fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q  <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      w0_q  <= w0_d;
      w1_q  <= w1_d;
      w2_q  <= w2_d;
      cnt_q <= cnt_d;
    end
  end

  // Sort sequencer: snapshot the window, three compare-exchange steps, then hold the median.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_sort) begin
            s0_q    <= w0_d;
            s1_q    <= w1_d;
            s2_q    <= w2_d;
            state_q <= S1;
          end
        end
        S1: begin
          s0_q    <= cx_lo;
          s1_q    <= cx_hi;
          state_q <= S2;
        end
        S2: begin
          s1_q    <= cx_lo;
          s2_q    <= cx_hi;
          state_q <= S3;
        end
        S3: begin
          s0_q        <= cx_lo;
          s1_q        <= cx_hi;
          out_data_q  <= cx_hi;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/median_stream.md
# median_stream

Streaming 3-tap median filter. Accepts one unsigned sample per valid/ready handshake and keeps a sliding window of the last three accepted samples. Each new sample triggers a multi-cycle compare-exchange sort of the window, and the block returns the window median on a valid/ready output port. It sits downstream of the sample source and replaces the purely combinational three-input median wherever samples arrive serially.

## Interface
- WIDTH, 8, sample width in bits; all comparisons unsigned
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous window clear; highest priority
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a sample; combinational: (state==IDLE) && !flush
- in_data  input  WIDTH  sample
- out_valid  output  1  out_data holds a median
- out_ready  input  1  consumer accepts the median
- out_data  output  WIDTH  median of the current window; registered

## Operation
- Window registers are w0 (newest), w1 and w2 (oldest). Sort registers are s0, s1 and s2. The fill counter cnt saturates at 3.
- Input handshake: in_valid && in_ready at a rising edge.
  - Shift the window: w2<=w1, w1<=w0, w0<=in_data.
  - cnt<=min(cnt+1,3).
- State machine: IDLE -> S1 -> S2 -> S3 -> OUT -> IDLE.
- IDLE, on handshake:
  - If the post-accept cnt is 3, copy the post-shift window into s0/s1/s2 and go to S1.
  - Otherwise stay in IDLE and produce no output.
- S1: compare-exchange (s0,s1). S2: compare-exchange (s1,s2). S3: compare-exchange (s0,s1), and load out_data <= the resulting s1.
- Compare-exchange swaps only when the left operand is strictly greater than the right, so equal values are never swapped.
- OUT: out_valid=1. On out_ready, go to IDLE and drop out_valid. out_data keeps its value after the handshake.
- flush=1 at an edge, in any state:
  - state<=IDLE, cnt<=0, out_valid<=0.
  - The window is logically discarded.
  - Any median in progress or pending is dropped.
  - No sample is accepted on that edge.
- Reset (asynchronous, rst_n=0, any time including mid-sort):
  - state=IDLE, cnt=0, w*/s*=0, out_data=0, out_valid=0.
  - in_ready=1 once rst_n=1 with flush=0.

## Timing
- Accept at edge N: S1, S2 and S3 execute at edges N+1, N+2 and N+3. out_valid is high from after edge N+3.
- Latency is 4 cycles from the accepting edge to the first cycle of out_valid.
- With out_ready held high, the output handshake occurs at edge N+4 and the next sample can be accepted at edge N+5. Peak throughput is therefore one sample per 5 cycles.
- Backpressure: while out_valid && !out_ready, out_data and out_valid hold stable and in_ready=0.
- in_ready is low in S1, S2, S3 and OUT. in_valid is ignored in those states.
- in_data is sampled only at a handshake edge.
- flush and in_valid high in the same cycle: flush wins, in_ready=0, and the sample is not consumed.
- Fill: without the macro, the first output is produced by the 3rd accepted sample after reset or flush.

## Configuration
- MEDIAN_EDGE_REPLICATE_EN defined:
  - A handshake with cnt==0 loads w0=w1=w2=in_data and sets cnt<=3. It then goes to S1 directly.
  - Every accepted sample, including the first after reset or flush, produces one median. The first median equals the first sample.
- Not defined: behaviour as above. The first two samples after reset or flush produce no output.

## Test plan
- Reset then samples 5, 9, 1, macro off -> no output after 5 or 9. After 1: out_valid 4 cycles after accept, out_data=5. Then sample 7 (window 9,1,7) -> out_data=7.
- Ties and extremes: samples 255, 0, 255 -> 255. Samples 3, 3, 8 -> 3. Samples 0, 0, 0 -> 0 (no spurious swap).
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1. Expect out_data stable, in_ready=0 and no extra sample consumed. Then raise out_ready -> one handshake and in_ready=1 the next cycle.
- flush in S2 after window 4, 2, 6 -> out_valid never rises and cnt restarts. Then samples 1, 2, 3 -> single output 2.
- Async reset asserted in S3 -> outputs return to reset values immediately without a clock. Then 10, 20, 30 -> 20.
- Macro on: reset, then sample 42 -> out_data=42 after 4 cycles. Then sample 10 (window 42,42,10) -> 42. Then sample 7 (window 42,10,7) -> 10.
